// File: rtl/r2sdf_bf4_if.sv
// Stream, delay-line and result signals of one r2sdf_bf4 stage.
// The slave modport is the stage; the master modport is its surroundings.
interface r2sdf_bf4_if #(
    parameter int unsigned W = 24
);
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] din_r;
    logic signed [W-1:0] din_i;
    logic                sr_en;
    logic signed [W-1:0] sr_din_r;
    logic signed [W-1:0] sr_din_i;
    logic signed [W-1:0] sr_dout_r;
    logic signed [W-1:0] sr_dout_i;
    logic                out_valid;
    logic signed [W-1:0] dout_r;
    logic signed [W-1:0] dout_i;

    modport master (
        output in_valid, din_r, din_i, sr_dout_r, sr_dout_i,
        input  in_ready, sr_en, sr_din_r, sr_din_i, out_valid, dout_r, dout_i
    );

    modport slave (
        input  in_valid, din_r, din_i, sr_dout_r, sr_dout_i,
        output in_ready, sr_en, sr_din_r, sr_din_i, out_valid, dout_r, dout_i
    );
endinterface

// File: rtl/r2sdf_bf4.sv
// Radix-2 single-delay-feedback butterfly, span 8, DIF twiddles, external 4-deep delay line.
// Each frame yields four sums, then four differences rotated by W8^k.
module r2sdf_bf4 #(
    parameter int unsigned W   = 24,
    parameter int unsigned TW  = 16,
    parameter int unsigned DLY = 4
) (
    input  logic       clk,
    input  logic       reset,
    r2sdf_bf4_if.slave bus
);

    localparam int unsigned CW = $clog2(DLY) + 1;
    localparam int unsigned MW = W + TW;
    localparam int unsigned PW = MW + 1;

    typedef logic signed [W-1:0] data_t;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_q, pend_d;
    logic          drain_q, drain_d;
    logic          out_valid_q, out_valid_d;
    data_t         dout_r_q, dout_r_d;
    data_t         dout_i_q, dout_i_d;

    logic                 in_ready, adv, phase;
    logic [1:0]           k;
    data_t                din_r_eff, din_i_eff;
    data_t                sum_r, sum_i, diff_r, diff_i;
    logic signed [TW-1:0] tw_r, tw_i;
    logic signed [MW-1:0] ac, bd, ad, bc;
    logic signed [PW-1:0] rnd_r, rnd_i;
    data_t                rot_r, rot_i;

    assign in_ready  = ~drain_q;
    assign adv       = (bus.in_valid & in_ready) | drain_q;
    assign phase     = cnt_q[CW-1];
    assign k         = cnt_q[1:0];
    // While draining, zeros are pushed in to flush the delay line.
    assign din_r_eff = drain_q ? '0 : bus.din_r;
    assign din_i_eff = drain_q ? '0 : bus.din_i;

    assign sum_r  = bus.sr_dout_r + din_r_eff;
    assign sum_i  = bus.sr_dout_i + din_i_eff;
    assign diff_r = bus.sr_dout_r - din_r_eff;
    assign diff_i = bus.sr_dout_i - din_i_eff;

    // W8^k in Q2.14
    always_comb begin
        tw_r = TW'(16384);
        tw_i = TW'(0);
        unique case (k)
            2'd0: begin tw_r = TW'(16384);  tw_i = TW'(0);      end
            2'd1: begin tw_r = TW'(11585);  tw_i = TW'(-11585); end
            2'd2: begin tw_r = TW'(0);      tw_i = TW'(-16384); end
            2'd3: begin tw_r = TW'(-11585); tw_i = TW'(-11585); end
        endcase
    end

    assign ac = MW'(bus.sr_dout_r) * MW'(tw_r);
    assign bd = MW'(bus.sr_dout_i) * MW'(tw_i);
    assign ad = MW'(bus.sr_dout_r) * MW'(tw_i);
    assign bc = MW'(bus.sr_dout_i) * MW'(tw_r);

    // Round half up, then keep the low W bits of the Q2.14-scaled result.
    assign rnd_r = PW'(ac) - PW'(bd) + PW'(2 ** 13);
    assign rnd_i = PW'(ad) + PW'(bc) + PW'(2 ** 13);
    assign rot_r = W'(rnd_r >>> 14);
    assign rot_i = W'(rnd_i >>> 14);

    assign bus.in_ready  = in_ready;
    assign bus.sr_en     = adv;
    assign bus.sr_din_r  = phase ? diff_r : din_r_eff;
    assign bus.sr_din_i  = phase ? diff_i : din_i_eff;
    assign bus.out_valid = out_valid_q;
    assign bus.dout_r    = dout_r_q;
    assign bus.dout_i    = dout_i_q;

    always_comb begin
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        drain_d     = drain_q;
        out_valid_d = 1'b0;
        dout_r_d    = dout_r_q;
        dout_i_d    = dout_i_q;

        // Input dried up at a frame boundary with diffs still pending: flush them.
        if (!drain_q && !bus.in_valid && cnt_q == '0 && pend_q) begin
            drain_d = 1'b1;
        end

        if (adv) begin
            cnt_d = cnt_q + CW'(1);
            if (phase) begin
                out_valid_d = 1'b1;
                dout_r_d    = sum_r;
                dout_i_d    = sum_i;
                if (cnt_q == '1) begin
                    pend_d = 1'b1;
                end
            end else if (pend_q) begin
                out_valid_d = 1'b1;
                dout_r_d    = rot_r;
                dout_i_d    = rot_i;
            end
            if (drain_q && cnt_q == CW'(DLY - 1)) begin
                drain_d = 1'b0;
                pend_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            drain_q     <= 1'b0;
            out_valid_q <= 1'b0;
            dout_r_q    <= '0;
            dout_i_q    <= '0;
        end else begin
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            drain_q     <= drain_d;
            out_valid_q <= out_valid_d;
            dout_r_q    <= dout_r_d;
            dout_i_q    <= dout_i_d;
        end
    end

endmodule

// File: tb/tb_r2sdf_bf4.sv
// Directed bench for r2sdf_bf4 with a behavioural 4-deep delay line.
// Each table row is one clock: inputs, then expected handshake, sr_din and registered output.
module tb_r2sdf_bf4;

    localparam int unsigned W = 24;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    r2sdf_bf4_if #(.W(W)) bus ();

    r2sdf_bf4 #(.W(W), .TW(16), .DLY(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic signed [W-1:0] dl_r [4] = '{default: '0};
    logic signed [W-1:0] dl_i [4] = '{default: '0};

    always @(posedge clk) begin
        if (bus.sr_en) begin
            dl_r[0] <= bus.sr_din_r;
            dl_i[0] <= bus.sr_din_i;
            for (int j = 1; j < 4; j++) begin
                dl_r[j] <= dl_r[j-1];
                dl_i[j] <= dl_i[j-1];
            end
        end
    end

    assign bus.sr_dout_r = dl_r[3];
    assign bus.sr_dout_i = dl_i[3];

    typedef struct {
        bit v;    int dr;   int di;
        bit rdy;  bit sren; int sd;
        bit ov;   int er;   int ei;
    } vec_t;

    vec_t tv[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Expected W8^k rotation of the diff -4 from a 1..8 frame.
    int tw_er [4] = '{-4, -3, 0, 3};
    int tw_ei [4] = '{0, 3, 4, 3};

    function automatic vec_t mk(bit v, int dr, int di, bit rdy, bit sren, int sd,
                                bit ov, int er, int ei);
        vec_t r;
        r.v = v;     r.dr = dr;     r.di = di;
        r.rdy = rdy; r.sren = sren; r.sd = sd;
        r.ov = ov;   r.er = er;     r.ei = ei;
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic run(input string tag);
        foreach (tv[i]) begin
            bus.in_valid = tv[i].v;
            bus.din_r    = W'(tv[i].dr);
            bus.din_i    = W'(tv[i].di);
            #2;
            chk($sformatf("%s[%0d].in_ready", tag, i), int'(bus.in_ready), int'(tv[i].rdy));
            chk($sformatf("%s[%0d].sr_en", tag, i), int'(bus.sr_en), int'(tv[i].sren));
            chk($sformatf("%s[%0d].sr_din_r", tag, i), int'(bus.sr_din_r), tv[i].sd);
            @(posedge clk);
            #1;
            chk($sformatf("%s[%0d].out_valid", tag, i), int'(bus.out_valid), int'(tv[i].ov));
            if (tv[i].ov) begin
                chk($sformatf("%s[%0d].dout_r", tag, i), int'(bus.dout_r), tv[i].er);
                chk($sformatf("%s[%0d].dout_i", tag, i), int'(bus.dout_i), tv[i].ei);
            end
        end
        tv.delete();
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        bus.din_r    = '0;
        bus.din_i    = '0;
        reset = 1'b1;
        #3;
        reset = 1'b0;
    endtask

    task automatic add_fill(input bit pending);
        for (int x = 1; x <= 4; x++) begin
            tv.push_back(mk(1, x, 0, 1, 1, x, pending, tw_er[x-1], tw_ei[x-1]));
        end
    endtask

    task automatic add_sums();
        for (int x = 5; x <= 8; x++) begin
            tv.push_back(mk(1, x, 0, 1, 1, -4, 1, 2 * x - 4, 0));
        end
    endtask

    // Entry cycle, four drain cycles, then idle.
    task automatic add_drain(input bit pulse);
        tv.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
        for (int k = 0; k < 4; k++) begin
            if (pulse && k == 1) tv.push_back(mk(1, 99, 55, 0, 1, 0, 1, tw_er[k], tw_ei[k]));
            else                 tv.push_back(mk(0, 0, 0, 0, 1, 0, 1, tw_er[k], tw_ei[k]));
        end
        tv.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.din_r    = '0;
        bus.din_i    = '0;
        @(posedge clk);
        #1;
        chk("por.dout_r", int'(bus.dout_r), 0);
        chk("por.dout_i", int'(bus.dout_i), 0);
        chk("por.out_valid", int'(bus.out_valid), 0);
        chk("por.in_ready", int'(bus.in_ready), 1);
        reset = 1'b0;

        // Single frame 1..8, then drain.
        do_reset();
        add_fill(0); add_sums(); add_drain(0);
        run("single");

        // in_valid pulsed while draining must be ignored.
        do_reset();
        add_fill(0); add_sums(); add_drain(1);
        run("ignore");

        // Two frames back to back: frame 1 rotations overlap frame 2 fill.
        do_reset();
        add_fill(0); add_sums(); add_fill(1); add_sums(); add_drain(0);
        run("b2b");

        // Three-cycle stall at cnt=5; sr_din there is sr_dout(=2) - din(0).
        do_reset();
        add_fill(0);
        tv.push_back(mk(1, 5, 0, 1, 1, -4, 1, 6, 0));
        for (int s = 0; s < 3; s++) tv.push_back(mk(0, 0, 0, 1, 0, 2, 0, 0, 0));
        for (int x = 6; x <= 8; x++) tv.push_back(mk(1, x, 0, 1, 1, -4, 1, 2 * x - 4, 0));
        add_drain(0);
        run("stall");

        // Wrap: 0x7FFFFF + 1 and a k2 rotation of -2^23.
        do_reset();
        tv.push_back(mk(1, 8388607, 0, 1, 1, 8388607, 0, 0, 0));
        tv.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0, 0));
        tv.push_back(mk(1, -8388608, 0, 1, 1, -8388608, 0, 0, 0));
        tv.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0, 0));
        tv.push_back(mk(1, 1, 0, 1, 1, 8388606, 1, -8388608, 0));
        tv.push_back(mk(1, 0, 0, 1, 1, 0, 1, 0, 0));
        tv.push_back(mk(1, 0, 0, 1, 1, -8388608, 1, -8388608, 0));
        tv.push_back(mk(1, 0, 0, 1, 1, 0, 1, 0, 0));
        tv.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 1, 0, 1, 8388606, 0));
        tv.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, -8388608));
        tv.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 0));
        tv.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
        run("wrap");

        // Reset mid-frame with diffs pending; next frame must start with sums only.
        do_reset();
        add_fill(0); add_sums();
        tv.push_back(mk(1, 1, 0, 1, 1, 1, 1, -4, 0));
        tv.push_back(mk(1, 2, 0, 1, 1, 2, 1, -3, 3));
        run("pre_rst");
        reset = 1'b1;
        #1;
        chk("midrst.dout_r", int'(bus.dout_r), 0);
        chk("midrst.dout_i", int'(bus.dout_i), 0);
        chk("midrst.out_valid", int'(bus.out_valid), 0);
        chk("midrst.in_ready", int'(bus.in_ready), 1);
        #2;
        reset = 1'b0;
        add_fill(0); add_sums(); add_drain(0);
        run("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
